// File: rtl/shift_counter_pkg.sv
// Shared constants and next-state helpers for the ring/Johnson counter.
// Vectors are carried at MAX_W bits and narrowed by the caller.
package shift_counter_pkg;

  localparam int MAX_W = 32;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_RIGHT    = 1'b0;
  localparam logic DIR_LEFT     = 1'b1;

  typedef logic [MAX_W-1:0] vec_t;

  function automatic vec_t mask(input int w);
    vec_t m;
    m = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t seed(input logic mode, input int w);
    vec_t s;
    s = '0;
    if (mode == MODE_RING) s = vec_t'(1) << (w - 1);
    return s;
  endfunction

  function automatic vec_t next_state(
    input vec_t v,
    input logic mode,
    input logic dir,
    input int   w
  );
    logic fill;
    vec_t r;
    if (dir == DIR_RIGHT) begin
      fill = (mode == MODE_JOHNSON) ? ~v[0] : v[0];
      r    = (v >> 1) | (vec_t'(fill) << (w - 1));
    end else begin
      fill = (mode == MODE_JOHNSON) ? ~v[w-1] : v[w-1];
      r    = ((v << 1) & mask(w)) | vec_t'(fill);
    end
    return r;
  endfunction

  // Johnson legal states are exactly those with at most one bit boundary.
  function automatic logic is_legal(
    input vec_t v,
    input logic mode,
    input int   w
  );
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < MAX_W; i++)
      if (i < w && v[i]) ones++;
    for (int i = 0; i < MAX_W - 1; i++)
      if (i < w - 1 && v[i] != v[i+1]) edges++;
    if (mode == MODE_JOHNSON) return edges <= 1;
    return ones == 1;
  endfunction

endpackage

// File: rtl/shift_counter_gen_tick_gen.sv
// Clock-enable divider: one registered tick every DIV_MAX+1 enabled cycles.
// clr restarts the phase and drops any pending tick.
module tick_gen #(
  parameter int DIV_MAX = 49_999_999
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int DW = (DIV_MAX > 0) ? $clog2(DIV_MAX + 1) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DIV_MAX);

  logic [DW-1:0] div;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (div == DMAX) begin
        div  <= '0;
        tick <= 1'b1;
      end else begin
        div  <= div + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Ring/Johnson shift counter with direction, parallel load,
// illegal-state recovery and a wrap pulse on return to the seed.
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DIV_MAX = 49_999_999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tick,
  output logic             wrap,
  output logic             illegal
);

  logic mode_q;
  logic mode_chg;
  logic legal;
  vec_t cur_v;
  vec_t nxt_v;
  vec_t cur_seed;
  vec_t new_seed;

  assign mode_chg = mode != mode_q;
  assign cur_v    = vec_t'(out);
  assign cur_seed = seed(mode_q, WIDTH);
  assign new_seed = seed(mode, WIDTH);
  assign legal    = is_legal(cur_v, mode_q, WIDTH);
  assign illegal  = ~legal;
  assign nxt_v    = legal ? next_state(cur_v, mode_q, dir, WIDTH)
                          : cur_seed;

  tick_gen #(
    .DIV_MAX(DIV_MAX)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load | mode_chg),
    .tick(tick)
  );

  // Load also adopts the present mode so the loaded value is not
  // immediately overwritten by a pending mode-change reseed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= WIDTH'(new_seed);
      mode_q <= mode;
      wrap   <= 1'b0;
    end else if (load) begin
      out    <= load_val;
      mode_q <= mode;
      wrap   <= 1'b0;
    end else if (mode_chg) begin
      out    <= WIDTH'(new_seed);
      mode_q <= mode;
      wrap   <= 1'b0;
    end else if (tick) begin
      out    <= WIDTH'(nxt_v);
      wrap   <= legal && (nxt_v == cur_seed);
    end else begin
      wrap   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_counter_gen.sv
// Directed bench for shift_counter_gen with WIDTH=4, DIV_MAX=2.
// Outputs are sampled 1 time unit after each rising edge.
module tb_shift_counter_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       mode;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] out;
  logic       tick;
  logic       wrap;
  logic       illegal;

  int checks;
  int errors;

  shift_counter_gen #(
    .WIDTH  (4),
    .DIV_MAX(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .out     (out),
    .tick    (tick),
    .wrap    (wrap),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m, input logic d);
    rst      = 1'b1;
    en       = 1'b1;
    mode     = m;
    dir      = d;
    load     = 1'b0;
    load_val = 4'b0000;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b1; dir = 1'b0;
    load = 1'b0; load_val = 4'b0000;
    cyc();
    checks++;
    if (out !== 4'b0000 || tick !== 1'b0 || wrap !== 1'b0 ||
        illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_johnson: out=%b tick=%b wrap=%b ill=%b want 0000 0 0 0",
               out, tick, wrap, illegal);
    end
    mode = 1'b0;
    cyc();
    checks++;
    if (out !== 4'b1000 || tick !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_ring: out=%b tick=%b ill=%b want 1000 0 0",
               out, tick, illegal);
    end
  endtask

  task automatic test_johnson();
    logic [3:0] seq [0:8];
    int idx;
    int wraps;
    seq[0] = 4'b0000; seq[1] = 4'b1000; seq[2] = 4'b1100;
    seq[3] = 4'b1110; seq[4] = 4'b1111; seq[5] = 4'b0111;
    seq[6] = 4'b0011; seq[7] = 4'b0001; seq[8] = 4'b0000;
    wraps = 0;
    do_reset(1'b1, 1'b0);
    for (int n = 1; n <= 26; n++) begin
      cyc();
      idx = (n >= 4) ? (n - 1) / 3 : 0;
      if (idx > 8) idx = 8;
      if (wrap) wraps++;
      checks++;
      if (out !== seq[idx] || tick !== (n % 3 == 0) ||
          wrap !== (n == 25)) begin
        errors++;
        $display("FAIL johnson_n%0d: out=%b tick=%b wrap=%b want %b %b %b",
                 n, out, tick, wrap, seq[idx], (n % 3 == 0), (n == 25));
      end
    end
    checks++;
    if (wraps != 1) begin
      errors++;
      $display("FAIL johnson_wrap_count: got %0d want 1", wraps);
    end
  endtask

  task automatic test_ring_dir();
    logic [3:0] seq [0:8];
    int idx;
    seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b0010;
    seq[3] = 4'b0001; seq[4] = 4'b1000; seq[5] = 4'b0100;
    seq[6] = 4'b0010; seq[7] = 4'b0100; seq[8] = 4'b1000;
    do_reset(1'b0, 1'b0);
    for (int n = 1; n <= 25; n++) begin
      cyc();
      idx = (n >= 4) ? (n - 1) / 3 : 0;
      checks++;
      if (out !== seq[idx] || wrap !== (n == 13 || n == 25) ||
          illegal !== 1'b0) begin
        errors++;
        $display("FAIL ring_n%0d: out=%b wrap=%b ill=%b want %b %b 0",
                 n, out, wrap, illegal, seq[idx], (n == 13 || n == 25));
      end
      if (n == 19) dir = 1'b1;
    end
  endtask

  task automatic test_load_illegal();
    do_reset(1'b0, 1'b0);
    load = 1'b1; load_val = 4'b0110;
    cyc();
    load = 1'b0;
    checks++;
    if (out !== 4'b0110 || illegal !== 1'b1 || tick !== 1'b0) begin
      errors++;
      $display("FAIL load_illegal: out=%b ill=%b tick=%b want 0110 1 0",
               out, illegal, tick);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (out !== 4'b0110 || tick !== 1'b1) begin
      errors++;
      $display("FAIL load_tick: out=%b tick=%b want 0110 1", out, tick);
    end
    cyc();
    checks++;
    if (out !== 4'b1000 || wrap !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL recover: out=%b wrap=%b ill=%b want 1000 0 0",
               out, wrap, illegal);
    end
  endtask

  task automatic test_mode_change();
    do_reset(1'b0, 1'b0);
    repeat (8) cyc();
    checks++;
    if (out !== 4'b0010) begin
      errors++;
      $display("FAIL mode_pre: out=%b want 0010", out);
    end
    mode = 1'b1;
    cyc();
    checks++;
    if (out !== 4'b0000 || illegal !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL mode_reseed: out=%b ill=%b tick=%b want 0000 0 0",
               out, illegal, tick);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (out !== 4'b0000 || tick !== 1'b1) begin
      errors++;
      $display("FAIL mode_tick: out=%b tick=%b want 0000 1", out, tick);
    end
    cyc();
    checks++;
    if (out !== 4'b1000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL mode_step: out=%b wrap=%b want 1000 0", out, wrap);
    end
  endtask

  task automatic test_en_hold();
    do_reset(1'b0, 1'b0);
    cyc(); cyc();
    en = 1'b0;
    for (int n = 3; n <= 12; n++) begin
      cyc();
      checks++;
      if (out !== 4'b1000 || tick !== 1'b0) begin
        errors++;
        $display("FAIL hold_n%0d: out=%b tick=%b want 1000 0", n, out, tick);
      end
    end
    en = 1'b1;
    cyc();
    checks++;
    if (out !== 4'b1000 || tick !== 1'b1) begin
      errors++;
      $display("FAIL resume_tick: out=%b tick=%b want 1000 1", out, tick);
    end
    cyc();
    checks++;
    if (out !== 4'b0100 || tick !== 1'b0) begin
      errors++;
      $display("FAIL resume_step: out=%b tick=%b want 0100 0", out, tick);
    end
  endtask

  task automatic test_load_vs_tick();
    do_reset(1'b0, 1'b0);
    cyc(); cyc(); cyc();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL lt_pretick: tick=%b want 1", tick);
    end
    load = 1'b1; load_val = 4'b0001;
    cyc();
    load = 1'b0;
    checks++;
    if (out !== 4'b0001 || tick !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL lt_load: out=%b tick=%b wrap=%b want 0001 0 0",
               out, tick, wrap);
    end
    cyc(); cyc(); cyc();
    checks++;
    if (out !== 4'b0001 || tick !== 1'b1) begin
      errors++;
      $display("FAIL lt_tick: out=%b tick=%b want 0001 1", out, tick);
    end
    cyc();
    checks++;
    if (out !== 4'b1000 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL lt_step: out=%b wrap=%b want 1000 1", out, wrap);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_johnson();
    test_ring_dir();
    test_load_illegal();
    test_mode_change();
    test_en_hold();
    test_load_vs_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_counter_gen.md
Name: shift_counter_gen

Overview:
- Parametrised ring/Johnson shift-register counter. Successor to the fixed 4-bit single-mode counter.
- Adds runtime mode select (ring or full 2*WIDTH-state Johnson), direction control, parallel load, illegal-state detection and self-recovery, and a wrap pulse.
- Steps on an internal clock-enable tick derived from clk; no derived clocks. Drives board LEDs or feeds sequencing logic.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- DIV_MAX, 49_999_999, tick period minus one, in clk cycles; 0 = step every enabled cycle.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  1 = tick divider runs; 0 = divider and counter hold.
- mode  in  1  0 = ring, 1 = Johnson.
- dir  in  1  0 = shift toward LSB, 1 = shift toward MSB.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value for load.
- out  out  WIDTH  counter state.
- tick  out  1  one-cycle step strobe (registered).
- wrap  out  1  one-cycle pulse when a step lands on the mode seed.
- illegal  out  1  combinational; 1 when out is not a legal state for the current mode.

Behaviour:
- Seeds: ring = MSB-only one-hot (WIDTH=4: 1000). Johnson = all zeros.
- Reset values: out = seed of the mode sampled in the rst cycle; divider = 0; tick = 0; wrap = 0; mode_q = mode.
- Divider: width $clog2(DIV_MAX+1).
  - en=1 and div==DIV_MAX: tick<=1, div<=0. Otherwise with en=1: div increments, tick<=0.
  - en=0: div holds, tick<=0.
- Step (registered tick=1), next-state by mode/dir:
  - Ring right: {out[0], out[W-1:1]}. Ring left: {out[W-2:0], out[W-1]}.
  - Johnson right: {~out[0], out[W-1:1]}. Johnson left: {out[W-2:0], ~out[W-1]}.
- Step latency: out changes on the edge after tick is high. Johnson period is 2*WIDTH steps; ring period is WIDTH steps.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: 1^k0^(W-k) or 0^k1^(W-k), for 0<=k<=W.
- Recovery: a step taken from an illegal state loads the seed instead of shifting. wrap stays 0 on recovery.
- Priority per edge: rst > load > mode change > step.
  - load: out<=load_val, div<=0, tick<=0, wrap<=0. Illegal values are accepted; illegal asserts.
  - Mode change (mode != mode_q): out<=seed(new mode), div<=0, mode_q<=mode, wrap<=0.
- dir change: no reload; takes effect at the next step.
- wrap: registered; 1 for exactly the cycle after a legal-state step produces out==seed.
- Simultaneous load and tick: load wins, and that tick is dropped.
- rst mid-count: divider phase is lost, and the first post-reset tick comes DIV_MAX+1 enabled cycles later.

Decomposition:
- Package shift_counter_pkg:
  - MODE_RING/MODE_JOHNSON constants, DIR_RIGHT/DIR_LEFT constants.
  - Functions seed(mode), next_state(out, mode, dir), is_legal(out, mode), parameterised by WIDTH.
- One sub-module: tick_gen (divider with en, sync clear, registered tick output), reused elsewhere for LED timing.

Test Plan (WIDTH=4, DIV_MAX=2):
- rst with mode=1, en=1, dir=0, hold 24 cycles -> out steps 0000,1000,1100,1110,1111,0111,0011,0001,0000, one step per 3 cycles; wrap pulses once on return to 0000.
- mode=0, dir=0 after reset -> 1000,0100,0010,0001,1000 with wrap at 1000; set dir=1 mid-sequence at 0010 -> next steps 0100,1000.
- load=1, load_val=0110, mode=0 -> out=0110 next edge, illegal=1; first step -> 1000, wrap=0, illegal=0.
- mode toggles 0->1 while out=0010 -> out=0000 next edge, divider restarts: next step 3 cycles later gives 1000.
- en=0 for 10 cycles mid-count -> out, div and tick frozen; resume continues the remaining count without a lost or extra step.
- load and tick asserted on the same edge (load_val=0001, mode=0) -> out=0001, no shift; next step 3 cycles later -> 1000 with wrap=1.
